// File: rtl/sram_model_pkg.sv
// -----------------------------------------------------------------------------
// sram_model_pkg
// Shared types and helpers for the single-port SRAM behavioural model.
//   state_t    : clear-sequencer states (ST_RESET, ST_INIT, ST_RUN)
//   FILL_MAX   : widest word the idle-fill helper can produce
//   ngran()    : number of write-mask granules in a word
//   rand_fill(): replicated 32-bit $random pattern, FILL_MAX bits wide;
//                callers size-cast it down to their own word width
// -----------------------------------------------------------------------------
package sram_model_pkg;

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_INIT  = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   localparam int FILL_MAX = 1024;

   function automatic int ngran(input int bits, input int gran);
      return bits / gran;
   endfunction

   function automatic logic [FILL_MAX-1:0] rand_fill();
      logic [31:0] r;
      r = $random;
      return {(FILL_MAX / 32){r}};
   endfunction

endpackage

// File: rtl/sram_sp_bwe_model_if.sv
// -----------------------------------------------------------------------------
// sram_sp_bwe_model_if
// Access bus of the single-port SRAM model.
//   CEB    : chip enable, active low
//   WEB    : write enable, active low (1 = read when CEB=0)
//   A      : word address
//   D      : write data
//   BWEB   : per-granule write mask, active low
//   Q      : read data
//   RVALID : Q carries read data this cycle
//   READY  : array accepts accesses
// master drives the request side, slave is the memory.
// -----------------------------------------------------------------------------
interface sram_sp_bwe_model_if #(
   parameter int BITS      = 64,
   parameter int ADD_WIDTH = 6,
   parameter int MASK_GRAN = 8
);
   import sram_model_pkg::*;

   localparam int NGRAN = ngran(BITS, MASK_GRAN);

   logic                 CEB;
   logic                 WEB;
   logic [ADD_WIDTH-1:0] A;
   logic [BITS-1:0]      D;
   logic [NGRAN-1:0]     BWEB;
   logic [BITS-1:0]      Q;
   logic                 RVALID;
   logic                 READY;

   modport master (
      output CEB, WEB, A, D, BWEB,
      input  Q, RVALID, READY
   );

   modport slave (
      input  CEB, WEB, A, D, BWEB,
      output Q, RVALID, READY
   );

endinterface

// File: rtl/sram_rd_pipe.sv
// -----------------------------------------------------------------------------
// sram_rd_pipe
// READ_LAT-deep register chain carrying {valid, data} from the array to Q.
//   CLK, RST  : clock, synchronous active-high reset (clears the chain)
//   in_valid  : a read was accepted at this edge
//   in_data   : word sampled from the array for that read
//   Q, RVALID : registered read data / strobe
// When the output slot carries no read data, Q takes a random fill
// (RAND_IDLE=1) or keeps its previous value (RAND_IDLE=0).
// -----------------------------------------------------------------------------
module sram_rd_pipe #(
   parameter int BITS      = 64,
   parameter int READ_LAT  = 1,
   parameter int RAND_IDLE = 1
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            in_valid,
   input  logic [BITS-1:0] in_data,
   output logic [BITS-1:0] Q,
   output logic            RVALID
);
   import sram_model_pkg::*;

   logic            src_valid;
   logic [BITS-1:0] src_data;

   // Latency 2 inserts one stage ahead of the output register.
   if (READ_LAT == 2) begin : g_pre
      logic            pre_valid;
      logic [BITS-1:0] pre_data;

      always_ff @(posedge CLK) begin
         if (RST) begin
            pre_valid <= 1'b0;
            pre_data  <= '0;
         end else begin
            pre_valid <= in_valid;
            pre_data  <= in_data;
         end
      end

      assign src_valid = pre_valid;
      assign src_data  = pre_data;
   end else begin : g_direct
      assign src_valid = in_valid;
      assign src_data  = in_data;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         Q      <= '0;
         RVALID <= 1'b0;
      end else begin
         RVALID <= src_valid;
         if (src_valid) begin
            Q <= src_data;
         end else if (RAND_IDLE != 0) begin
            Q <= BITS'(rand_fill());
         end
      end
   end

endmodule

// File: rtl/sram_sp_bwe_model.sv
// -----------------------------------------------------------------------------
// sram_sp_bwe_model
// Behavioural single-port synchronous SRAM with active-low per-granule write
// mask, 1- or 2-cycle read latency, read-valid strobe and an optional
// power-on clear sweep.
//   CLK : clock, all logic on posedge
//   RST : synchronous active-high reset
//   bus : sram_sp_bwe_model_if.slave (CEB, WEB, A, D, BWEB -> Q, RVALID, READY)
// Accesses are honoured only once READY is high. Out-of-range writes are
// dropped; out-of-range reads return zero with RVALID set.
// -----------------------------------------------------------------------------
module sram_sp_bwe_model #(
   parameter int BITS        = 64,
   parameter int WORD_DEPTH  = 64,
   parameter int ADD_WIDTH   = 6,
   parameter int MASK_GRAN   = 8,
   parameter int READ_LAT    = 1,
   parameter int INIT_ON_RST = 1,
   parameter int RAND_IDLE   = 1
) (
   input logic                CLK,
   input logic                RST,
   sram_sp_bwe_model_if.slave bus
);
   import sram_model_pkg::*;

   localparam int                   NGRAN     = ngran(BITS, MASK_GRAN);
   localparam logic [ADD_WIDTH-1:0] LAST_ADDR = ADD_WIDTH'(WORD_DEPTH - 1);

   if (BITS % MASK_GRAN != 0) begin : g_bad_gran
      $fatal(1, "sram_sp_bwe_model: BITS must be a multiple of MASK_GRAN");
   end
   if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
      $fatal(1, "sram_sp_bwe_model: READ_LAT must be 1 or 2");
   end
   if ((64'(1) << ADD_WIDTH) < 64'(WORD_DEPTH)) begin : g_bad_addr
      $fatal(1, "sram_sp_bwe_model: ADD_WIDTH too small for WORD_DEPTH");
   end
   if (BITS > FILL_MAX) begin : g_bad_bits
      $fatal(1, "sram_sp_bwe_model: BITS exceeds FILL_MAX");
   end

   logic [BITS-1:0]      mem [WORD_DEPTH];
   state_t               state;
   logic [ADD_WIDTH-1:0] cnt;
   logic                 ready_r;

   logic                 in_range;
   logic                 accept;
   logic                 rd_en;
   logic                 wr_en;
   logic [BITS-1:0]      bit_mask;
   logic [BITS-1:0]      cur_word;
   logic [BITS-1:0]      wr_word;

   // Expand the granule mask to a per-bit write enable.
   always_comb begin
      // NOTE: assign a default before the loop so every bit is driven on every
      // pass; a combinational output left unassigned on some path infers a latch.
      bit_mask = '0;
      for (int g = 0; g < NGRAN; g++) begin
         bit_mask[g*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{~bus.BWEB[g]}};
      end
   end

   // Reset wins over a same-edge access; nothing is accepted outside RUN.
   assign in_range = int'(bus.A) < WORD_DEPTH;
   assign accept   = (state == ST_RUN) && !RST && !bus.CEB;
   assign rd_en    = accept && bus.WEB;
   assign wr_en    = accept && !bus.WEB && in_range;

   // Out-of-range reads see zero; a masked write merges into the stored word.
   assign cur_word = in_range ? mem[bus.A] : '0;
   assign wr_word  = (cur_word & ~bit_mask) | (bus.D & bit_mask);

   // NOTE: the array has no reset branch on purpose; its contents are cleared
   // by the INIT sweep one word per cycle, exactly as a real macro would be.
   always_ff @(posedge CLK) begin
      if (state == ST_INIT) begin
         mem[cnt] <= '0;
      end else if (wr_en) begin
         mem[bus.A] <= wr_word;
      end
   end

   // Clear sequencer. READY is registered and rises on the edge entering RUN.
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (RST) begin
         state   <= ST_RESET;
         cnt     <= '0;
         ready_r <= 1'b0;
      end else begin
         case (state)
            ST_RESET: begin
               cnt <= '0;
               if (INIT_ON_RST != 0) begin
                  state <= ST_INIT;
               end else begin
                  state   <= ST_RUN;
                  ready_r <= 1'b1;
               end
            end
            ST_INIT: begin
               if (cnt == LAST_ADDR) begin
                  state   <= ST_RUN;
                  ready_r <= 1'b1;
                  cnt     <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_RUN: begin
               ready_r <= 1'b1;
            end
            default: begin
               state   <= ST_RESET;
               ready_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.READY = ready_r;

   sram_rd_pipe #(
      .BITS      (BITS),
      .READ_LAT  (READ_LAT),
      .RAND_IDLE (RAND_IDLE)
   ) u_rd_pipe (
      .CLK      (CLK),
      .RST      (RST),
      .in_valid (rd_en),
      .in_data  (cur_word),
      .Q        (bus.Q),
      .RVALID   (bus.RVALID)
   );

endmodule
